onchip_mem_pipelined: RTL

Parametrised single-port on-chip memory with an Avalon-MM pipelined slave interface (read/write, byteenable, waitrequest, readdatavalid) and a configurable 1- or 2-cycle read latency. It can optionally sweep the whole array to zero after reset. It replaces fixed-geometry instruction/data RAM slaves in NIOS-based systems where width, depth and pipelining must vary per instance. Storage is an inferred RAM array, not a vendor primitive.

---
 rtl/onchip_mem_pipelined_if.sv | 36 +++
 rtl/onchip_mem_pipelined.sv | 132 +++++++++++++
 2 files changed

// File: rtl/onchip_mem_pipelined_if.sv
// -----------------------------------------------------------------------------
// onchip_mem_pipelined_if
// Avalon-MM pipelined bus bundle between a master and onchip_mem_pipelined.
//   address       master -> slave  word address
//   byteenable    master -> slave  write byte lanes
//   chipselect    master -> slave  slave select
//   read / write  master -> slave  transfer requests
//   writedata     master -> slave  write data
//   waitrequest   slave -> master  request not accepted this cycle
//   readdata      slave -> master  read data, qualified by readdatavalid
//   readdatavalid slave -> master  one pulse per accepted read
// -----------------------------------------------------------------------------
interface onchip_mem_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_pipelined.sv
// -----------------------------------------------------------------------------
// onchip_mem_pipelined
// Single-port inferred RAM with an Avalon-MM pipelined slave port, 1- or
// 2-cycle read latency and an optional zero sweep after every reset release.
//   clk        rising-edge system clock
//   reset_n    asynchronous active-low reset
//   clken      clock enable; low freezes array access, sweep and read pipeline
//   init_done  high once the block accepts traffic
//   bus        Avalon-MM slave modport (see onchip_mem_pipelined_if)
// -----------------------------------------------------------------------------
module onchip_mem_pipelined #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDR_WIDTH     = 14,
    parameter int    READ_LATENCY   = 1,
    parameter int    CLEAR_ON_RESET = 0,
    parameter string INIT_FILE      = ""
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    output logic                  init_done,
    onchip_mem_pipelined_if.slave bus
);
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("onchip_mem_pipelined: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("onchip_mem_pipelined: DATA_WIDTH must be a multiple of 8");
    end
    if (CLEAR_ON_RESET != 0 && INIT_FILE != "") begin : g_init_overridden
    end

    typedef enum logic {S_CLEAR, S_READY} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    state_t                state, state_next;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic                  clear_we;
    logic                  waitrequest_c;
    logic                  init_done_c;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  v1;
    logic [DATA_WIDTH-1:0] q1;

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (clear_we) cnt <= cnt_inc;
        end
    end

    // Outputs are qualified with reset_n so that the READY reset state still
    // presents waitrequest=1 / init_done=0 while reset is held.
    always_comb begin
        state_next    = state;
        clear_we      = 1'b0;
        waitrequest_c = 1'b1;
        init_done_c   = 1'b0;
        unique case (state)
            S_CLEAR: begin
                if (reset_n && clken) begin
                    clear_we = 1'b1;
                    if (cnt_inc[ADDR_WIDTH]) state_next = S_READY;
                end
            end
            S_READY: begin
                init_done_c   = reset_n;
                waitrequest_c = ~(clken & reset_n);
            end
        endcase
    end

    assign init_done       = init_done_c;
    assign bus.waitrequest = waitrequest_c;

    // waitrequest already folds in clken, so accepted transfers imply clken=1.
    assign wr_accept = bus.chipselect & bus.write & ~waitrequest_c;
    assign rd_accept = bus.chipselect & bus.read & ~bus.write & ~waitrequest_c;

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (wr_accept) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (bus.byteenable[i]) mem[bus.address][8*i +: 8] <= bus.writedata[8*i +: 8];
            end
        end
    end

    // Stage 1 samples the array at the acceptance edge (read-before-write).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            q1 <= '0;
        end else if (clken) begin
            v1 <= rd_accept;
            if (rd_accept) q1 <= mem[bus.address];
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  v2;
        logic [DATA_WIDTH-1:0] q2;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v2 <= 1'b0;
                q2 <= '0;
            end else if (clken) begin
                v2 <= v1;
                if (v1) q2 <= q1;
            end
        end

        assign bus.readdatavalid = v2;
        assign bus.readdata      = q2;
    end else begin : g_lat1
        assign bus.readdatavalid = v1;
        assign bus.readdata      = q1;
    end
endmodule
